vid_loop_pipe: RTL and testbench

Parametrised video loop-through stage for the HDMI input-to-output path. Delays the input video bus (hs/vs/de/data) by a configurable number of pixel clocks, measures active width/height of every frame, and declares lock after a programmable run of identical frames. Output data can be forced to black unconditionally or automatically while the input is unstable, so the HDMI transmitter never shows torn or garbage frames.

---
 rtl/vid_loop_pipe.sv | 235 +++++++++++++++++++++++
 tb/tb_vid_loop_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_loop_pipe.sv
// Fixed-latency HDMI loop-through stage: delays the video bus, measures each frame,
// tracks lock on a run of identical frames and blanks pixel data when asked or unstable.
module vid_loop_pipe #(
    parameter int unsigned DW          = 24,
    parameter int unsigned DELAY       = 3,
    parameter int unsigned HCNT_W      = 12,
    parameter int unsigned VCNT_W      = 12,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 4000000
) (
    input  logic              vin_clk,
    input  logic              rst_n,
    input  logic              vin_hs,
    input  logic              vin_vs,
    input  logic              vin_de,
    input  logic [DW-1:0]     vin_data,
    input  logic [1:0]        mode,
    output logic              vout_hs,
    output logic              vout_vs,
    output logic              vout_de,
    output logic [DW-1:0]     vout_data,
    output logic [HCNT_W-1:0] h_active,
    output logic [VCNT_W-1:0] v_active,
    output logic              stable
);

    localparam int unsigned BW   = DW + 3;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_CHECK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // ---------------------------------------------------------------- delay line
    // Bus word layout: {hs, vs, de, data}
    logic [BW-1:0] stage_in [DELAY];
    logic [BW-1:0] pipe     [DELAY];
    logic [BW-1:0] last_in;
    logic [1:0]    mode_q;
    logic [1:0]    mode_eff;
    logic          out_frame_start;
    logic          mute;

    assign stage_in[0] = {vin_hs, vin_vs, vin_de, vin_data};

    for (genvar g = 1; g < DELAY; g++) begin : g_link
        assign stage_in[g] = pipe[g-1];
    end

    // The mode sampled at an output frame start already governs that frame's first word
    assign out_frame_start = stage_in[DELAY-1][DW+1] & ~pipe[DELAY-1][DW+1];
    assign mode_eff        = out_frame_start ? mode : mode_q;
    assign mute            = (mode_eff == 2'd1) || ((mode_eff == 2'd2) && !stable);

    always_comb begin
        last_in = stage_in[DELAY-1];
        if (mute) begin
            last_in[DW-1:0] = '0;
        end
    end

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                pipe[i] <= '0;
            end
            mode_q <= 2'd0;
        end else begin
            for (int i = 0; i < int'(DELAY) - 1; i++) begin
                pipe[i] <= stage_in[i];
            end
            pipe[DELAY-1] <= last_in;
            mode_q        <= mode_eff;
        end
    end

    assign {vout_hs, vout_vs, vout_de, vout_data} = pipe[DELAY-1];

    // ---------------------------------------------------------------- measurement
    logic              de_d;
    logic              vs_d;
    logic [HCNT_W-1:0] pix_cnt;
    logic [HCNT_W-1:0] ref_w;
    logic [HCNT_W-1:0] ref_w_nxt;
    logic [VCNT_W-1:0] line_cnt;
    logic [VCNT_W-1:0] line_cnt_nxt;
    logic              frame_bad;
    logic              frame_bad_nxt;
    logic              line_end;
    logic              frame_close;
    logic              frame_ok;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_nxt;
    logic              wd_hit;

    assign line_end    = de_d & ~vin_de;
    assign frame_close = ~vs_d & vin_vs;

    // Fold a line ending this cycle into the totals before a same-cycle frame close
    always_comb begin
        line_cnt_nxt  = line_cnt;
        ref_w_nxt     = ref_w;
        frame_bad_nxt = frame_bad;
        if (line_end) begin
            if (line_cnt != '1) begin
                line_cnt_nxt = line_cnt + VCNT_W'(1);
            end
            if (line_cnt == '0) begin
                ref_w_nxt = pix_cnt;
            end else if (pix_cnt != ref_w) begin
                frame_bad_nxt = 1'b1;
            end
        end
    end

    // h_active/v_active double as the previous-frame reference
    assign frame_ok = !frame_bad_nxt && (line_cnt_nxt != '0)
                      && (ref_w_nxt == h_active) && (line_cnt_nxt == v_active);

    always_comb begin
        if (frame_close) begin
            wd_nxt = '0;
        end else if (wd_cnt == WD_W'(TIMEOUT)) begin
            wd_nxt = wd_cnt;
        end else begin
            wd_nxt = wd_cnt + WD_W'(1);
        end
    end

    assign wd_hit = (wd_nxt == WD_W'(TIMEOUT));

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d      <= 1'b0;
            vs_d      <= 1'b0;
            pix_cnt   <= '0;
            ref_w     <= '0;
            line_cnt  <= '0;
            frame_bad <= 1'b0;
            wd_cnt    <= '0;
            h_active  <= '0;
            v_active  <= '0;
        end else begin
            de_d   <= vin_de;
            vs_d   <= vin_vs;
            wd_cnt <= wd_nxt;
            if (frame_close) begin
                pix_cnt   <= '0;
                ref_w     <= '0;
                line_cnt  <= '0;
                frame_bad <= 1'b0;
            end else begin
                ref_w     <= ref_w_nxt;
                line_cnt  <= line_cnt_nxt;
                frame_bad <= frame_bad_nxt;
                if (line_end) begin
                    pix_cnt <= '0;
                end else if (vin_de && (pix_cnt != '1)) begin
                    pix_cnt <= pix_cnt + HCNT_W'(1);
                end
            end
            if (wd_hit) begin
                h_active <= '0;
                v_active <= '0;
            end else if (frame_close) begin
                h_active <= ref_w_nxt;
                v_active <= line_cnt_nxt;
            end
        end
    end

    // ---------------------------------------------------------------- lock FSM
    state_t     state;
    state_t     state_nxt;
    logic [3:0] match_cnt;
    logic [3:0] match_nxt;

    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_UNLOCK;
            match_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        if (wd_hit) begin
            state_nxt = S_UNLOCK;
            match_nxt = 4'd0;
        end else if (frame_close) begin
            case (state)
                S_UNLOCK: begin
                    if (frame_ok) begin
                        match_nxt = 4'd1;
                        state_nxt = (LOCK_FRAMES == 1) ? S_LOCKED : S_CHECK;
                    end else begin
                        match_nxt = 4'd0;
                    end
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        match_nxt = match_cnt + 4'd1;
                        if ((match_cnt + 4'd1) >= 4'(LOCK_FRAMES)) begin
                            state_nxt = S_LOCKED;
                        end
                    end else begin
                        state_nxt = S_UNLOCK;
                        match_nxt = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (!frame_ok) begin
                        state_nxt = S_UNLOCK;
                        match_nxt = 4'd0;
                    end
                end
                default: begin
                    state_nxt = S_UNLOCK;
                    match_nxt = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        stable = (state == S_LOCKED);
    end

endmodule

// File: tb/tb_vid_loop_pipe.sv
// Bench for vid_loop_pipe: frame table, hand-built mute/timeout/reset sequences and
// randomized frames, all checked every cycle against a frame-level reference model.
module tb_vid_loop_pipe;

    localparam int unsigned DW          = 24;
    localparam int unsigned DELAY       = 3;
    localparam int unsigned HCNT_W      = 12;
    localparam int unsigned VCNT_W      = 12;
    localparam int unsigned LOCK_FRAMES = 2;
    localparam int          TIMEOUT     = 1000;
    localparam int unsigned BW          = DW + 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hs;
    logic              vs;
    logic              de;
    logic [DW-1:0]     data;
    logic [1:0]        mode;
    logic              vout_hs;
    logic              vout_vs;
    logic              vout_de;
    logic [DW-1:0]     vout_data;
    logic [HCNT_W-1:0] h_active;
    logic [VCNT_W-1:0] v_active;
    logic              stable;

    vid_loop_pipe #(
        .DW(DW), .DELAY(DELAY), .HCNT_W(HCNT_W), .VCNT_W(VCNT_W),
        .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)
    ) dut (
        .vin_clk(clk), .rst_n(rst_n),
        .vin_hs(hs), .vin_vs(vs), .vin_de(de), .vin_data(data), .mode(mode),
        .vout_hs(vout_hs), .vout_vs(vout_vs), .vout_de(vout_de), .vout_data(vout_data),
        .h_active(h_active), .v_active(v_active), .stable(stable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int live_px = 0;
    int zero_px = 0;

    // Reference model state
    logic [BW-1:0] hist[$];
    logic [BW-1:0] m_exp;
    logic          m_vs_out;
    logic [1:0]    m_mode;
    bit            m_prev_de;
    bit            m_prev_vs;
    int            m_run;
    int            widths[$];
    int            m_prev_w;
    int            m_prev_l;
    int            m_h;
    int            m_v;
    int            m_okrun;
    int            m_since;
    bit            m_stable;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        widths.delete();
        m_exp     = '0;
        m_vs_out  = 1'b0;
        m_mode    = 2'd0;
        m_prev_de = 1'b0;
        m_prev_vs = 1'b0;
        m_run     = 0;
        m_prev_w  = 0;
        m_prev_l  = 0;
        m_h       = 0;
        m_v       = 0;
        m_okrun   = 0;
        m_since   = 0;
        m_stable  = 1'b0;
    endtask

    // One clock edge of the reference: bus history, frame-start mode latch, frame bookkeeping
    task automatic model_edge();
        logic [BW-1:0] e;
        bit mute;
        bit closing;
        bit same;
        bit ok;
        int w;
        hist.push_front({hs, vs, de, data});
        if (hist.size() > DELAY) void'(hist.pop_back());
        e = (hist.size() == DELAY) ? hist[DELAY-1] : '0;
        if (e[DW+1] && !m_vs_out) m_mode = mode;
        m_vs_out = e[DW+1];
        mute = (m_mode == 2'd1) || (m_mode == 2'd2 && !m_stable);
        if (mute) e[DW-1:0] = '0;
        m_exp = e;

        if (de) m_run++;
        if (m_prev_de && !de) begin
            widths.push_back(m_run);
            m_run = 0;
        end
        closing   = !m_prev_vs && vs;
        m_prev_de = de;
        m_prev_vs = vs;
        if (closing) begin
            w = (widths.size() != 0) ? widths[0] : 0;
            same = 1'b1;
            foreach (widths[i]) if (widths[i] != w) same = 1'b0;
            ok = same && (widths.size() != 0) && (w == m_prev_w) && (widths.size() == m_prev_l);
            m_prev_w = w;
            m_prev_l = widths.size();
            m_h      = w;
            m_v      = widths.size();
            m_okrun  = ok ? m_okrun + 1 : 0;
            widths.delete();
            m_run   = 0;
            m_since = 0;
        end else begin
            if (m_since < TIMEOUT) m_since++;
            if (m_since == TIMEOUT) begin
                m_okrun  = 0;
                m_prev_w = 0;
                m_prev_l = 0;
                m_h      = 0;
                m_v      = 0;
            end
        end
        m_stable = (m_okrun >= int'(LOCK_FRAMES));
    endtask

    task automatic compare_outputs();
        check("vout_hs", vout_hs, m_exp[DW+2]);
        check("vout_vs", vout_vs, m_exp[DW+1]);
        check("vout_de", vout_de, m_exp[DW]);
        check("vout_data", vout_data, m_exp[DW-1:0]);
        check("h_active", h_active, m_h);
        check("v_active", v_active, m_v);
        check("stable", stable, m_stable);
        if (vout_de) begin
            if (vout_data == '0) zero_px++;
            else live_px++;
        end
    endtask

    task automatic step(input logic h, input logic v, input logic d);
        hs   = h;
        vs   = v;
        de   = d;
        data = d ? (DW'($urandom) | DW'(1)) : DW'($urandom);
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic send_line(input int w);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < w; p++) step(1'b0, 1'b0, 1'b1);
    endtask

    // Lines of a frame, ending with the vs rising-edge cycle that closes it
    task automatic send_frame(input int w, input int n, input int bad_idx, input int bad_w,
                              input bit simul, input int chg_line, input logic [1:0] chg_mode);
        for (int l = 0; l < n; l++) begin
            if (l == chg_line) mode = chg_mode;
            send_line((l == bad_idx) ? bad_w : w);
            if (!(simul && l == n - 1)) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic vblank();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        hs = 1'b0; vs = 1'b0; de = 1'b0; data = '0;
        #1;
        check("rst_vout_hs", vout_hs, 0);
        check("rst_vout_vs", vout_vs, 0);
        check("rst_vout_de", vout_de, 0);
        check("rst_vout_data", vout_data, 0);
        check("rst_h_active", h_active, 0);
        check("rst_v_active", v_active, 0);
        check("rst_stable", stable, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int w;
        int n;
        int bad_idx;
        int bad_w;
        bit simul;
        int exp_h;
        int exp_v;
        bit exp_st;
    } frame_vec_t;

    frame_vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit actual=%0t required=finished", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0]  = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b0};
        vecs[1]  = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b0};
        vecs[2]  = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b1};
        vecs[3]  = '{8, 4,  1, 7, 1'b0, 8, 4, 1'b0};
        vecs[4]  = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b0};
        vecs[5]  = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b1};
        vecs[6]  = '{6, 3, -1, 0, 1'b0, 6, 3, 1'b0};
        vecs[7]  = '{6, 3, -1, 0, 1'b1, 6, 3, 1'b0};
        vecs[8]  = '{8, 4, -1, 0, 1'b1, 8, 4, 1'b0};
        vecs[9]  = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b0};
        vecs[10] = '{8, 4, -1, 0, 1'b0, 8, 4, 1'b1};

        rst_n = 1'b1;
        hs = 1'b0; vs = 1'b0; de = 1'b0; data = '0; mode = 2'd0;
        model_reset();
        do_reset();

        // Frame table: measurement, lock, drop on bad line, same-cycle de fall / vs rise
        foreach (vecs[i]) begin
            send_frame(vecs[i].w, vecs[i].n, vecs[i].bad_idx, vecs[i].bad_w, vecs[i].simul, -1, 2'd0);
            check($sformatf("tbl%0d_h", i), h_active, vecs[i].exp_h);
            check($sformatf("tbl%0d_v", i), v_active, vecs[i].exp_v);
            check($sformatf("tbl%0d_stable", i), stable, vecs[i].exp_st);
            vblank();
        end

        // Mode 1 written mid-frame: current output frame untouched, next one black
        live_px = 0; zero_px = 0;
        send_frame(8, 4, -1, 0, 1'b0, 2, 2'd1);
        vblank();
        check("m1_cur_live", live_px, 32);
        check("m1_cur_zero", zero_px, 0);
        live_px = 0; zero_px = 0;
        send_frame(8, 4, -1, 0, 1'b0, 2, 2'd2);
        vblank();
        check("m1_next_zero", zero_px, 32);
        check("m1_next_live", live_px, 0);

        // Mode 2 while locked passes; after a bad frame unlocks, next output frame is black
        live_px = 0; zero_px = 0;
        send_frame(8, 4, -1, 0, 1'b0, -1, 2'd2);
        vblank();
        check("m2_locked_live", live_px, 32);
        live_px = 0; zero_px = 0;
        send_frame(8, 4, 1, 7, 1'b0, -1, 2'd2);
        check("m2_bad_stable", stable, 0);
        vblank();
        check("m2_bad_live", live_px, 31);
        live_px = 0; zero_px = 0;
        send_frame(8, 4, -1, 0, 1'b0, -1, 2'd2);
        check("m2_relock1_stable", stable, 0);
        vblank();
        check("m2_unlocked_zero", zero_px, 32);
        send_frame(8, 4, -1, 0, 1'b0, -1, 2'd2);
        check("m2_relock2_stable", stable, 1);

        // Watchdog: no vs rising edge for TIMEOUT clocks
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(1'b0, (k <= 2), 1'b0);
            if (k == TIMEOUT - 1) begin
                check("wd_pre_stable", stable, 1);
                check("wd_pre_h", h_active, 8);
            end
            if (k == TIMEOUT) begin
                check("wd_stable", stable, 0);
                check("wd_h", h_active, 0);
                check("wd_v", v_active, 0);
            end
        end

        // Reset in the middle of a frame: lines before reset are discarded
        mode = 2'd0;
        send_frame(8, 4, -1, 0, 1'b0, -1, 2'd0);
        check("post_wd_stable", stable, 0);
        vblank();
        send_line(8);
        step(1'b0, 1'b0, 1'b0);
        send_line(8);
        do_reset();
        send_frame(8, 2, -1, 0, 1'b0, -1, 2'd0);
        check("rst_mid_v", v_active, 2);
        check("rst_mid_h", h_active, 8);
        check("rst_mid_stable", stable, 0);
        vblank();

        // Randomized frames, mostly a repeating format so lock is reached and lost
        for (int f = 0; f < 40; f++) begin
            int w;
            int n;
            int bad;
            int gap;
            int cl;
            bit sim;
            if ($urandom_range(0, 3) == 0) begin
                w = $urandom_range(4, 10);
                n = $urandom_range(1, 5);
            end else begin
                w = 8;
                n = 4;
            end
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            sim = 1'($urandom_range(0, 1));
            cl  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            send_frame(w, n, bad, w - 1, sim, cl, 2'($urandom_range(0, 3)));
            vblank();
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
